// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/shift/logic ops plus an optional
// shift-add multiply, with ARM-gated write enable and CARRY/SKIP flag registers.
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      instr,
  input  logic [WIDTH-1:0] rd_data,
  input  logic [WIDTH-1:0] rs_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_out,
  output logic             wen,
  output logic             carry_q,
  output logic             skip_q
);

  localparam int unsigned W     = WIDTH;
  localparam int unsigned W1    = WIDTH + 1;
  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam bit          HAS_MUL = (MUL_EN != 0);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t state;

  // Instruction fields
  logic [1:0] code;
  logic [1:0] cin_sel;
  logic [3:0] cond;
  logic       cw;
  logic [2:0] op;
  logic       arm;
  logic       unused_instr_bits;

  assign {code, cin_sel, cond, cw, op} = instr[15:4];
  assign arm               = (code == 2'b11);
  assign unused_instr_bits = ^instr[3:0];

  // Captured fields needed when a multiply completes
  logic             arm_q;
  logic [3:0]       cond_q;
  logic             cw_q;

  // Multiply datapath
  logic [W2-1:0]    acc;
  logic [W2-1:0]    mcand;
  logic [W-1:0]     mplier;
  logic [CNT_W-1:0] cnt;
  logic [W2-1:0]    pp_acc;
  logic             mul_last;
  logic             is_mul_op;

  assign pp_acc    = acc + (mplier[0] ? mcand : '0);
  assign mul_last  = (cnt == CNT_W'(W - 1));
  assign is_mul_op = HAS_MUL && (op == 3'b100);

  // Carry-in selection; CIN=10 sees the flag as it stood before this instruction
  logic cin;
  always_comb begin
    cin = 1'b0;
    case (cin_sel)
      2'b00:   cin = 1'b0;
      2'b01:   cin = 1'b1;
      2'b10:   cin = carry_q;
      default: cin = rs_data[W-1];
    endcase
  end

  // Single-cycle operations
  logic [W1-1:0] sum;
  logic [W-1:0]  res;
  logic          cout;
  always_comb begin
    sum  = '0;
    res  = '0;
    cout = 1'b0;
    case (op)
      3'b000:  sum = {1'b0, rd_data} + {1'b0, rs_data} + W1'(cin);
      3'b001:  sum = {1'b0, rd_data} + {1'b0, ~rs_data} + W1'(cin);
      3'b010:  sum = {1'b0, rs_data} + W1'(cin);
      default: sum = '0;
    endcase
    case (op)
      3'b000, 3'b001, 3'b010: begin
        res  = sum[W-1:0];
        cout = sum[W];
      end
      3'b011: begin
        res  = {cin, rs_data[W-1:1]};
        cout = rs_data[0];
      end
      3'b101:  res = rd_data & rs_data;
      3'b110:  res = rd_data ^ rs_data;
      default: begin
        res  = '0;
        cout = 1'b0;
      end
    endcase
  end

  // Completing result: fresh inputs in IDLE, final partial product in MUL
  logic [W-1:0] fin_res;
  logic         fin_cout;
  logic         fin_arm;
  logic         fin_cw;
  logic [3:0]   fin_cond;
  logic         skip_base;
  logic         fin_skip;
  always_comb begin
    fin_res  = res;
    fin_cout = cout;
    fin_arm  = arm;
    fin_cw   = cw;
    fin_cond = cond;
    if (state == MUL) begin
      fin_res  = pp_acc[W-1:0];
      fin_cout = |pp_acc[W2-1:W];
      fin_arm  = arm_q;
      fin_cw   = cw_q;
      fin_cond = cond_q;
    end
    skip_base = 1'b0;
    case (fin_cond[2:0])
      3'b001:  skip_base = fin_cout;
      3'b010:  skip_base = (fin_res == '0);
      3'b011:  skip_base = fin_res[W-1];
      default: skip_base = 1'b0;
    endcase
    fin_skip = skip_base ^ fin_cond[3];
  end

  // Control FSM, operand capture, result and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      wen       <= 1'b0;
      alu_out   <= '0;
      carry_q   <= 1'b0;
      skip_q    <= 1'b0;
      arm_q     <= 1'b0;
      cond_q    <= '0;
      cw_q      <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      out_valid <= 1'b0;
      wen       <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            arm_q  <= arm;
            cond_q <= cond;
            cw_q   <= cw;
            mplier <= rd_data;
            mcand  <= W2'(rs_data);
            acc    <= '0;
            cnt    <= '0;
            if (is_mul_op) begin
              state    <= MUL;
              in_ready <= 1'b0;
            end else begin
              out_valid <= 1'b1;
              wen       <= fin_arm;
              alu_out   <= fin_res;
              if (fin_arm && fin_cw) carry_q <= fin_cout;
              if (fin_arm) skip_q <= fin_skip;
            end
          end
        end
        MUL: begin
          acc    <= pp_acc;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (mul_last) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b1;
            wen       <= fin_arm;
            alu_out   <= fin_res;
            if (fin_arm && fin_cw) carry_q <= fin_cout;
            if (fin_arm) skip_q <= fin_skip;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=16): directed cases plus random instructions,
// checked against an arithmetic reference model of the instruction set.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] instr = '0;
  logic [15:0] rd_data = '0;
  logic [15:0] rs_data = '0;
  logic        out_valid;
  logic [15:0] alu_out;
  logic        wen;
  logic        carry_q;
  logic        skip_q;

  int vectors = 0;
  int miscompares = 0;
  logic m_carry = 1'b0;
  logic m_skip = 1'b0;

  alu_seq #(.WIDTH(16), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rd_data(rd_data), .rs_data(rs_data),
    .out_valid(out_valid), .alu_out(alu_out), .wen(wen),
    .carry_q(carry_q), .skip_q(skip_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: result and carry-out straight from the instruction rules
  function automatic void model(input logic [15:0] ins, input logic [15:0] a,
                                input logic [15:0] b, output logic [15:0] r,
                                output logic co);
    int unsigned     t;
    longint unsigned p;
    logic            ci;
    case (ins[13:12])
      2'd0:    ci = 1'b0;
      2'd1:    ci = 1'b1;
      2'd2:    ci = m_carry;
      default: ci = b[15];
    endcase
    r = 16'h0; co = 1'b0; t = 0; p = 0;
    case (ins[6:4])
      3'd0: begin t = a + b + ci;               r = t[15:0]; co = t[16]; end
      3'd1: begin t = a + (16'hFFFF - b) + ci;  r = t[15:0]; co = t[16]; end
      3'd2: begin t = b + ci;                   r = t[15:0]; co = t[16]; end
      3'd3: begin r = (b >> 1) | (ci ? 16'h8000 : 16'h0000); co = b[0]; end
      3'd4: begin p = a * b; r = p[15:0]; co = ((p >> 16) != 0); end
      3'd5: r = a & b;
      3'd6: r = a ^ b;
      default: ;
    endcase
  endfunction

  function automatic logic model_skip(input logic [3:0] c, input logic [15:0] r, input logic co);
    logic base;
    case (c[2:0])
      3'd1:    base = co;
      3'd2:    base = (r == 16'h0);
      3'd3:    base = r[15];
      default: base = 1'b0;
    endcase
    return base ^ c[3];
  endfunction

  // One transfer, then wait for and check its result pulse
  task automatic issue(input logic [15:0] ins, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] er;
    logic        ec, es, arm;
    int          lat, lows, elat;
    model(ins, a, b, er, ec);
    es   = model_skip(ins[11:8], er, ec);
    arm  = (ins[15:14] == 2'b11);
    elat = (ins[6:4] == 3'd4) ? 17 : 1;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    instr = ins; rd_data = a; rs_data = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    instr = 16'($urandom); rd_data = 16'($urandom); rs_data = 16'($urandom);
    lat = 0; lows = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!in_ready) lows++;
    end while (!out_valid && lat < 40);
    if (arm && ins[7]) m_carry = ec;
    if (arm) m_skip = es;
    chk("latency", 32'(lat), 32'(elat));
    chk("ready_low_cycles", 32'(lows), 32'(elat - 1));
    chk("alu_out", 32'(alu_out), 32'(er));
    chk("wen", 32'(wen), 32'(arm));
    chk("carry_q", 32'(carry_q), 32'(m_carry));
    chk("skip_q", 32'(skip_q), 32'(m_skip));
    @(negedge clk);
    chk("pulse_one_cycle", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] ins, a, b, pr;
    logic        pc, pa;
    logic [15:0] op_pick;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_alu_out", 32'(alu_out), 32'd0);
    chk("rst_carry", 32'(carry_q), 32'd0);
    chk("rst_skip", 32'(skip_q), 32'd0);
    rst_n = 1'b1;

    // Directed: MUL with carry already 0, ADD, XSR, SUB with CIN=carry, non-ARM
    issue(16'hC0C0, 16'h0012, 16'h0034);
    chk("mul_result", 32'(alu_out), 32'h03A8);
    chk("mul_carry", 32'(carry_q), 32'd0);
    issue(16'hC280, 16'hFFFF, 16'h0001);
    chk("add_result", 32'(alu_out), 32'h0000);
    chk("add_carry", 32'(carry_q), 32'd1);
    chk("add_skip", 32'(skip_q), 32'd1);
    issue(16'hD0B0, 16'h1234, 16'h0003);
    chk("xsr_result", 32'(alu_out), 32'h8001);
    chk("xsr_carry", 32'(carry_q), 32'd1);
    issue(16'hE010, 16'h0005, 16'h0005);
    chk("sub_result", 32'(alu_out), 32'h0000);
    chk("sub_carry_held", 32'(carry_q), 32'd1);
    issue(16'h4000, 16'h00FF, 16'h0F0F);
    chk("nonarm_carry_held", 32'(carry_q), 32'd1);
    issue(16'hC0F0, 16'h1234, 16'h5678);
    chk("op111_zero", 32'(alu_out), 32'h0000);
    issue(16'hC3C0, 16'hFFFF, 16'hFFFF);

    // Random instructions, mostly ARM
    for (int i = 0; i < 150; i++) begin
      ins = 16'($urandom);
      if ($urandom_range(3) != 0) ins[15:14] = 2'b11;
      issue(ins, 16'($urandom), 16'($urandom));
    end

    // Back-to-back single-cycle ops, one result per cycle
    pr = '0; pc = 1'b0; pa = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_result", 32'(alu_out), 32'(pr));
        chk("b2b_carry", 32'(carry_q), 32'(m_carry));
        chk("b2b_wen", 32'(wen), 32'(pa));
      end
      if (k == 8) begin
        in_valid = 1'b0;
      end else begin
        ins = 16'($urandom);
        ins[15:14] = 2'b11;
        op_pick = 16'($urandom_range(6));
        if (op_pick == 16'd4) op_pick = 16'd7;
        ins[6:4] = op_pick[2:0];
        a = 16'($urandom); b = 16'($urandom);
        model(ins, a, b, pr, pc);
        pa = 1'b1;
        if (ins[7]) m_carry = pc;
        m_skip = model_skip(ins[11:8], pr, pc);
        instr = ins; rd_data = a; rs_data = b; in_valid = 1'b1;
      end
    end
    @(negedge clk);
    chk("b2b_end_idle", 32'(out_valid), 32'd0);

    // Reset aborts a multiply in progress; carry set first so the clear is visible
    issue(16'hC280, 16'hFFFF, 16'h0001);
    chk("pre_abort_carry", 32'(carry_q), 32'd1);
    @(negedge clk);
    instr = 16'hC0C0; rd_data = 16'h0012; rs_data = 16'h0034; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    m_carry = 1'b0; m_skip = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_carry", 32'(carry_q), 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    rst_n = 1'b1;
    instr = 16'hC280; rd_data = 16'h7FFF; rs_data = 16'h8001; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_result", 32'(alu_out), 32'h0000);
    chk("post_rst_carry", 32'(carry_q), 32'd1);
    m_carry = 1'b1; m_skip = 1'b1;
    issue(16'hC0C0, 16'h0100, 16'h0100);
    chk("mul_overflow_carry", 32'(carry_q), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
